// File: rtl/fetch_queue_pkg.sv
// Shared CPU constants and fetch-queue defaults/entry layout.
package fetch_queue_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [XLEN-1:0] PC_RESET = 32'h1c00_0000;

  localparam int unsigned     FQ_DEPTH    = 4;
  localparam logic [XLEN-1:0] FQ_NOP_INST = 32'h0340_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            adef;
  } fq_entry_t;

  // Misaligned fetches never reach decode with real data; a NOP carries the ADEF flag instead.
  function automatic fq_entry_t fq_make_entry(input logic [XLEN-1:0] pc,
                                              input logic [XLEN-1:0] rdata,
                                              input logic            adef,
                                              input logic [XLEN-1:0] nop_inst);
    fq_entry_t e;
    e.pc   = pc;
    e.inst = adef ? nop_inst : rdata;
    e.adef = adef;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// IF1/icache request side and decode handshake side of the fetch queue.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic            if1_req;
  logic [XLEN-1:0] if1_pc;
  logic            if1_adef;
  logic            pc_wen;
  logic            icache_rvalid;
  logic [XLEN-1:0] icache_rdata;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_inst;
  logic            id_adef;

  modport master (
    output if1_req, if1_pc, if1_adef, icache_rvalid, icache_rdata, id_ready,
    input  pc_wen, id_valid, id_pc, id_inst, id_adef
  );

  modport slave (
    input  if1_req, if1_pc, if1_adef, icache_rvalid, icache_rdata, id_ready,
    output pc_wen, id_valid, id_pc, id_inst, id_adef
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Circular entry storage for fetched instructions; storage itself is not reset.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  fq_entry_t                push_entry,
  input  logic                     pop,
  output fq_entry_t                head_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fq_entry_t        mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_entry;
  end

  assign head_entry = mem[head];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between IF1/icache and decode: pending-request register, credit check, FIFO.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH    = FQ_DEPTH,
  parameter logic [XLEN-1:0] NOP_INST = FQ_NOP_INST
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  fetch_queue_if.slave        bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            pend_valid;
  logic [XLEN-1:0] pend_pc;
  logic            pend_adef;

  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            accept;
  logic            push;
  logic            pop;
  fq_entry_t       push_entry;
  fq_entry_t       head_entry;

  // The in-flight request already owns a slot, so credit counts it alongside stored entries.
  always_comb begin
    occupancy     = {1'b0, count} + (CW+1)'(pend_valid);
    bus.pc_wen    = !flush && (!rst_n || (occupancy < (CW+1)'(DEPTH)));
    accept        = bus.if1_req && bus.pc_wen;
    push          = bus.icache_rvalid && pend_valid && !flush;
    bus.id_valid  = rst_n && (count != '0);
    pop           = bus.id_valid && bus.id_ready && !flush;
    push_entry    = fq_make_entry(pend_pc, bus.icache_rdata, pend_adef, NOP_INST);
    bus.id_pc     = head_entry.pc;
    bus.id_inst   = head_entry.inst;
    bus.id_adef   = head_entry.adef;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      pend_valid <= 1'b0;
    end else if (accept) begin
      pend_valid <= 1'b1;
    end else if (push) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_pc   <= bus.if1_pc;
      pend_adef <= bus.if1_adef;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: latency, fill/backpressure, ADEF, flush and reset recovery.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_checks;
  int   n_errors;

  fetch_queue_if bus ();

  fetch_queue #(
    .DEPTH    (4),
    .NOP_INST (32'h0340_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5a5a_0000;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.if1_req       = 1'b0;
    bus.if1_pc        = '0;
    bus.if1_adef      = 1'b0;
    bus.icache_rvalid = 1'b0;
    bus.icache_rdata  = '0;
    bus.id_ready      = 1'b0;
  endtask

  // Accept one request, answer it next cycle, then check the head entry.
  task automatic fetch_one(input string tag, input logic [31:0] pc, input logic [31:0] rdata);
    bus.if1_req = 1'b1;
    bus.if1_pc  = pc;
    cyc();
    bus.if1_req       = 1'b0;
    bus.icache_rvalid = 1'b1;
    bus.icache_rdata  = rdata;
    cyc();
    bus.icache_rvalid = 1'b0;
    settle();
    check({tag, "_valid"}, 32'(bus.id_valid), 32'd1);
    check({tag, "_pc"}, bus.id_pc, pc);
    check({tag, "_inst"}, bus.id_inst, rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic        exp_wen [6];
  logic [31:0] nxt;
  logic [31:0] acc_pc;
  logic        prev_acc;
  logic [31:0] base;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    idle();
    exp_wen = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // reset
    cyc();
    settle();
    check("rst_id_valid", 32'(bus.id_valid), 32'd0);
    check("rst_pc_wen", 32'(bus.pc_wen), 32'd1);
    cyc();
    rst_n = 1'b1;
    settle();
    check("post_rst_id_valid", 32'(bus.id_valid), 32'd0);
    check("post_rst_pc_wen", 32'(bus.pc_wen), 32'd1);

    // first fetch, two-cycle latency
    bus.if1_req = 1'b1;
    bus.if1_pc  = PC_RESET;
    settle();
    check("t1_accept", 32'(bus.pc_wen), 32'd1);
    cyc();
    bus.if1_req       = 1'b0;
    bus.icache_rvalid = 1'b1;
    bus.icache_rdata  = 32'h0280_0c0c;
    settle();
    check("t1_not_yet", 32'(bus.id_valid), 32'd0);
    cyc();
    bus.icache_rvalid = 1'b0;
    settle();
    check("t1_valid", 32'(bus.id_valid), 32'd1);
    check("t1_pc", bus.id_pc, 32'h1c00_0000);
    check("t1_inst", bus.id_inst, 32'h0280_0c0c);
    check("t1_adef", 32'(bus.id_adef), 32'd0);
    bus.id_ready = 1'b1;
    cyc();
    bus.id_ready = 1'b0;
    settle();
    check("t1_popped", 32'(bus.id_valid), 32'd0);

    // stray response with nothing pending
    bus.icache_rvalid = 1'b1;
    bus.icache_rdata  = 32'hdead_beef;
    cyc();
    bus.icache_rvalid = 1'b0;
    settle();
    check("stray_id_valid", 32'(bus.id_valid), 32'd0);
    check("stray_pc_wen", 32'(bus.pc_wen), 32'd1);

    // fill with decode stalled: 4 accepts, then pc_wen drops
    nxt      = PC_RESET;
    acc_pc   = '0;
    prev_acc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.if1_req       = 1'b1;
      bus.if1_pc        = nxt;
      bus.icache_rvalid = prev_acc;
      bus.icache_rdata  = inst_of(acc_pc);
      settle();
      check($sformatf("t2_wen_%0d", i), 32'(bus.pc_wen), 32'(exp_wen[i]));
      if (exp_wen[i]) begin
        acc_pc = nxt;
        nxt    = nxt + 32'd4;
      end
      prev_acc = exp_wen[i];
      cyc();
    end
    bus.if1_req       = 1'b0;
    bus.icache_rvalid = 1'b0;
    settle();
    check("t2_full_valid", 32'(bus.id_valid), 32'd1);
    check("t2_full_head", bus.id_pc, 32'h1c00_0000);
    check("t2_full_wen", 32'(bus.pc_wen), 32'd0);

    // one pop frees exactly one slot
    bus.id_ready = 1'b1;
    bus.if1_req  = 1'b1;
    bus.if1_pc   = nxt;
    settle();
    check("t3_wen_full", 32'(bus.pc_wen), 32'd0);
    check("t3_head", bus.id_pc, 32'h1c00_0000);
    check("t3_head_inst", bus.id_inst, 32'h0280_0c0c ^ 32'h0280_0c0c ^ inst_of(32'h1c00_0000));
    cyc();
    bus.id_ready = 1'b0;
    settle();
    check("t3_wen_after_pop", 32'(bus.pc_wen), 32'd1);
    cyc();
    bus.if1_req       = 1'b0;
    bus.icache_rvalid = 1'b1;
    bus.icache_rdata  = inst_of(32'h1c00_0010);
    settle();
    check("t3_wen_pending", 32'(bus.pc_wen), 32'd0);
    cyc();
    bus.icache_rvalid = 1'b0;
    settle();
    check("t3_wen_full_again", 32'(bus.pc_wen), 32'd0);
    for (int k = 0; k < 4; k++) begin
      bus.id_ready = 1'b1;
      settle();
      check($sformatf("t3_drain_valid_%0d", k), 32'(bus.id_valid), 32'd1);
      check($sformatf("t3_drain_pc_%0d", k), bus.id_pc, 32'h1c00_0004 + 32'(4 * k));
      check($sformatf("t3_drain_inst_%0d", k), bus.id_inst, inst_of(32'h1c00_0004 + 32'(4 * k)));
      cyc();
    end
    bus.id_ready = 1'b0;
    settle();
    check("t3_empty", 32'(bus.id_valid), 32'd0);

    // misaligned fetch becomes a NOP with ADEF
    bus.if1_req  = 1'b1;
    bus.if1_pc   = 32'h1c00_0002;
    bus.if1_adef = 1'b1;
    cyc();
    bus.if1_req       = 1'b0;
    bus.if1_adef      = 1'b0;
    bus.icache_rvalid = 1'b1;
    bus.icache_rdata  = 32'hffff_ffff;
    cyc();
    bus.icache_rvalid = 1'b0;
    settle();
    check("t4_valid", 32'(bus.id_valid), 32'd1);
    check("t4_pc", bus.id_pc, 32'h1c00_0002);
    check("t4_inst", bus.id_inst, 32'h0340_0000);
    check("t4_adef", 32'(bus.id_adef), 32'd1);
    bus.id_ready = 1'b1;
    cyc();
    bus.id_ready = 1'b0;

    // 3 queued + pending, flush together with the pending response
    base = 32'h1c00_0040;
    for (int j = 0; j < 4; j++) begin
      bus.if1_req       = 1'b1;
      bus.if1_pc        = base + 32'(4 * j);
      bus.icache_rvalid = (j > 0);
      bus.icache_rdata  = inst_of(base + 32'(4 * j) - 32'd4);
      cyc();
    end
    flush             = 1'b1;
    bus.icache_rvalid = 1'b1;
    bus.icache_rdata  = inst_of(base + 32'd12);
    bus.if1_req       = 1'b1;
    bus.if1_pc        = base + 32'd16;
    bus.id_ready      = 1'b1;
    settle();
    check("t5_flush_wen", 32'(bus.pc_wen), 32'd0);
    cyc();
    flush = 1'b0;
    idle();
    settle();
    check("t5_after_valid", 32'(bus.id_valid), 32'd0);
    check("t5_after_wen", 32'(bus.pc_wen), 32'd1);
    cyc();
    settle();
    check("t5_still_empty", 32'(bus.id_valid), 32'd0);
    fetch_one("t5_refetch", 32'h1c00_0100, inst_of(32'h1c00_0100));
    bus.id_ready = 1'b1;
    cyc();
    bus.id_ready = 1'b0;
    settle();
    check("t5_drained", 32'(bus.id_valid), 32'd0);

    // reset mid-operation: 2 queued + pending
    base = 32'h1c00_0080;
    for (int j = 0; j < 3; j++) begin
      bus.if1_req       = 1'b1;
      bus.if1_pc        = base + 32'(4 * j);
      bus.icache_rvalid = (j > 0);
      bus.icache_rdata  = inst_of(base + 32'(4 * j) - 32'd4);
      cyc();
    end
    rst_n             = 1'b0;
    bus.if1_req       = 1'b0;
    bus.icache_rvalid = 1'b1;
    bus.icache_rdata  = inst_of(base + 32'd8);
    bus.id_ready      = 1'b1;
    settle();
    check("t6_in_reset_valid", 32'(bus.id_valid), 32'd0);
    check("t6_in_reset_wen", 32'(bus.pc_wen), 32'd1);
    cyc();
    rst_n = 1'b1;
    idle();
    settle();
    check("t6_after_valid", 32'(bus.id_valid), 32'd0);
    check("t6_after_wen", 32'(bus.pc_wen), 32'd1);
    fetch_one("t6_first", PC_RESET, 32'h0280_0c0c);
    bus.id_ready = 1'b1;
    cyc();
    bus.id_ready = 1'b0;
    settle();
    check("t6_drained", 32'(bus.id_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
